// File: rtl/logic_unit_serial_pkg.sv
// ============================================================================
//  Module : logic_unit_pkg
//  Brief  : Op codes and FSM state encoding for the serial logic unit.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package logic_unit_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOR   = 3'b011;
    localparam logic [2:0] OP_ANDN  = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Codes above PASSA are reserved and flagged as illegal.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_PASSA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/logic_slice.sv
// ============================================================================
//  Module : logic_slice
//  Brief  : Combinational SLICE-bit bitwise logic cell with illegal-op flag.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [2:0]       i_op,
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    output logic [SLICE-1:0] o_y,
    output logic             o_illegal
);

    always_comb begin
        o_y       = '0;
        o_illegal = !op_is_legal(i_op);
        case (i_op)
            OP_AND:   o_y = i_a & i_b;
            OP_OR:    o_y = i_a | i_b;
            OP_XOR:   o_y = i_a ^ i_b;
            OP_NOR:   o_y = ~(i_a | i_b);
            OP_ANDN:  o_y = i_a & ~i_b;
            OP_PASSA: o_y = i_a;
            default:  o_y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/logic_unit_serial.sv
// ============================================================================
//  Module : logic_unit_serial
//  Brief  : Multi-cycle WIDTH-bit logic unit, SLICE bits per cycle, start/done.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module logic_unit_serial
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             err
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] c_last = IW'(N - 1);

    generate
        if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_param_check
            $error("logic_unit_serial: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_err;

    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_y;
    logic             w_illegal;
    logic [WIDTH-1:0] w_acc_next;

    assign w_a_slice = r_a[r_idx*SLICE +: SLICE];
    assign w_b_slice = r_b[r_idx*SLICE +: SLICE];

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_op      (r_op),
        .i_a       (w_a_slice),
        .i_b       (w_b_slice),
        .o_y       (w_y),
        .o_illegal (w_illegal)
    );

    // Accumulator with the current slice merged in; on the last slice this is the result.
    always_comb begin
        w_acc_next                       = r_acc;
        w_acc_next[r_idx*SLICE +: SLICE] = w_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_op    <= OP_AND;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_zero  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    if (r_idx == c_last) begin
                        r_out   <= w_acc_next;
                        r_zero  <= (w_acc_next == '0);
                        r_err   <= w_illegal;
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign out  = r_out;
    assign zero = r_zero;
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_serial.sv
// ============================================================================
//  Module : tb_logic_unit_serial
//  Brief  : Directed-vector bench for logic_unit_serial (SLICE = 8, 32, 1).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_logic_unit_serial;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  zero_v;
    logic [2:0]  err_v;
    logic [31:0] out_v [3];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic_unit_serial #(.WIDTH(32), .SLICE(8)) dut8 (
        .clk (clk), .rst_n (rst_n), .start (start_v[0]), .op (op), .a (a), .b (b),
        .busy (busy_v[0]), .done (done_v[0]), .out (out_v[0]), .zero (zero_v[0]), .err (err_v[0])
    );

    logic_unit_serial #(.WIDTH(32), .SLICE(32)) dut32 (
        .clk (clk), .rst_n (rst_n), .start (start_v[1]), .op (op), .a (a), .b (b),
        .busy (busy_v[1]), .done (done_v[1]), .out (out_v[1]), .zero (zero_v[1]), .err (err_v[1])
    );

    logic_unit_serial #(.WIDTH(32), .SLICE(1)) dut1 (
        .clk (clk), .rst_n (rst_n), .start (start_v[2]), .op (op), .a (a), .b (b),
        .busy (busy_v[2]), .done (done_v[2]), .out (out_v[2]), .zero (zero_v[2]), .err (err_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one op on instance k; returns cycles from Start to Done (sampled at negedge).
    task automatic run_op(input int k, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, output int lat);
        @(negedge clk);
        op = o; a = av; b = bv; start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        lat = 1;
        while (!done_v[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int ndone;
    int d1;
    int d2;
    bit stray_done;

    initial begin
        rst_n = 1'b0; start_v = '0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy_v[0]}, 32'd0);
        check("rst_done", {31'd0, done_v[0]}, 32'd0);
        check("rst_out",  out_v[0], 32'h0);
        check("rst_zero", {31'd0, zero_v[0]}, 32'd1);
        check("rst_err",  {31'd0, err_v[0]}, 32'd0);
        rst_n = 1'b1;

        run_op(0, 3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, lat);
        check("and_lat",  lat, 32'd5);
        check("and_out",  out_v[0], 32'h0F0F_0000);
        check("and_zero", {31'd0, zero_v[0]}, 32'd0);
        check("and_busy", {31'd0, busy_v[0]}, 32'd1);

        run_op(0, 3'b011, 32'hAAAA_AAAA, 32'hAAAA_AAAA, lat);
        check("nor_out",  out_v[0], 32'h5555_5555);
        run_op(0, 3'b010, 32'hAAAA_AAAA, 32'hAAAA_AAAA, lat);
        check("xor_out",  out_v[0], 32'h0);
        check("xor_zero", {31'd0, zero_v[0]}, 32'd1);
        check("xor_err",  {31'd0, err_v[0]}, 32'd0);

        run_op(0, 3'b100, 32'h1234_5678, 32'h0000_FFFF, lat);
        check("andn_out", out_v[0], 32'h1234_0000);
        run_op(0, 3'b101, 32'h1234_5678, 32'h0000_FFFF, lat);
        check("passa_out", out_v[0], 32'h1234_5678);

        // Reset while idx == 2 of an AND.
        @(negedge clk);
        op = 3'b000; a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", {31'd0, busy_v[0]}, 32'd0);
        check("mrst_out",  out_v[0], 32'h0);
        check("mrst_zero", {31'd0, zero_v[0]}, 32'd1);
        check("mrst_err",  {31'd0, err_v[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[0]) stray_done = 1'b1;
        end
        check("mrst_nodone", {31'd0, stray_done}, 32'd0);

        run_op(0, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("ill_out",  out_v[0], 32'h0);
        check("ill_zero", {31'd0, zero_v[0]}, 32'd1);
        check("ill_err",  {31'd0, err_v[0]}, 32'd1);
        run_op(0, 3'b001, 32'h1234_5678, 32'h0000_FFFF, lat);
        check("or_out", out_v[0], 32'h1234_FFFF);
        check("or_err", {31'd0, err_v[0]}, 32'd0);

        // Start held for 12 cycles; A changed while the first op runs.
        @(negedge clk);
        op = 3'b000; a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; start_v[0] = 1'b1;
        ndone = 0; d1 = 0; d2 = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 2) a = 32'h0000_0000;
            if (cyc == 7) check("hs_out_hold", out_v[0], 32'h0F0F_0000);
            if (done_v[0]) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = cyc;
                    check("hs_out1", out_v[0], 32'h0F0F_0000);
                end else begin
                    d2 = cyc;
                    check("hs_out2", out_v[0], 32'h0);
                end
            end
        end
        start_v[0] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        check("hs_ndone", ndone, 32'd2);
        check("hs_d1", d1, 32'd5);
        check("hs_d2", d2, 32'd11);
        check("hs_idle", {31'd0, busy_v[0]}, 32'd0);

        run_op(1, 3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, lat);
        check("s32_lat",  lat, 32'd2);
        check("s32_out",  out_v[1], 32'h0F0F_0000);
        check("s32_zero", {31'd0, zero_v[1]}, 32'd0);
        check("s32_err",  {31'd0, err_v[1]}, 32'd0);
        check("s32_busy", {31'd0, busy_v[1]}, 32'd1);

        run_op(2, 3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, lat);
        check("s1_lat",  lat, 32'd33);
        check("s1_out",  out_v[2], 32'h0F0F_0000);
        check("s1_zero", {31'd0, zero_v[2]}, 32'd0);
        check("s1_err",  {31'd0, err_v[2]}, 32'd0);
        check("s1_busy", {31'd0, busy_v[2]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
